// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if
//   Bundles the ID-stage instruction description and the unit's results.
//   master : pipeline side (drives the ID instruction, flush, cnt_clr).
//   slave  : fwd_hazard_unit (drives stall, fwd_sel, stall_cnt).
//   Handshake: none. The ID inputs are sampled every clock while id_valid is
//   high. stall is combinational in the same cycle. fwd_sel belongs to the
//   instruction that entered EX at the last edge.
interface fwd_hazard_unit_if #(
  parameter int NREAD = 2,
  parameter int SELW  = 2,
  parameter int CNT_W = 16
);
  logic                  id_valid;
  logic [NREAD*5-1:0]    id_src;
  logic [NREAD-1:0]      id_src_used;
  logic [4:0]            id_rd;
  logic                  id_regwrite;
  logic                  id_is_load;
  logic                  flush;
  logic                  cnt_clr;
  logic                  stall;
  logic [NREAD*SELW-1:0] fwd_sel;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output id_valid, id_src, id_src_used, id_rd, id_regwrite, id_is_load,
           flush, cnt_clr,
    input  stall, fwd_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_src, id_src_used, id_rd, id_regwrite, id_is_load,
           flush, cnt_clr,
    output stall, fwd_sel, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Operand forwarding select and load-use stall detection for NREAD source
//   operands and NSTAGES forwarding sources. A shadow pipeline of in-flight
//   destinations (E0 = EX, P1..P(NSTAGES-1) = later stages) advances every
//   clock. A stall never freezes it; the stall only inserts a bubble into E0.
// Ports
//   clk, reset : pipeline clock, asynchronous active-high reset
//   bus        : fwd_hazard_unit_if.slave
//                in  id_valid, id_src, id_src_used, id_rd, id_regwrite,
//                    id_is_load, flush, cnt_clr
//                out stall (comb), fwd_sel (registered into EX),
//                    stall_cnt (saturating)
module fwd_hazard_unit #(
  parameter int NREAD      = 2,
  parameter int NSTAGES    = 2,
  parameter int LOAD_READY = 2,
  parameter int ZERO_REG   = 31,
  parameter int CNT_W      = 16
) (
  input  logic           clk,
  input  logic           reset,
  fwd_hazard_unit_if.slave bus
);

  localparam int SELW = ($clog2(NSTAGES + 1) < 1) ? 1 : $clog2(NSTAGES + 1);
  localparam logic [4:0] ZR = 5'(ZERO_REG);

  // Shadow entry j sits at forward index j+1.
  logic       sh_v  [NSTAGES];
  logic [4:0] sh_rd [NSTAGES];
  logic       sh_wr [NSTAGES];
  logic       sh_ld [NSTAGES];

  logic [SELW-1:0]       match_idx [NREAD];
  logic                  hz        [NREAD];
  logic                  any_hz;
  logic                  stall;
  logic                  kill;
  logic [NREAD*SELW-1:0] fwd_q;
  logic [CNT_W-1:0]      cnt_q;

  // Scan from oldest to youngest so the youngest matching producer wins.
  always_comb begin
    any_hz = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      match_idx[i] = '0;
      hz[i]        = 1'b0;
      for (int j = NSTAGES - 1; j >= 0; j--) begin
        if (sh_v[j] && sh_wr[j] && (sh_rd[j] != ZR) &&
            (sh_rd[j] == bus.id_src[5*i +: 5])) begin
          match_idx[i] = SELW'(j + 1);
          hz[i]        = sh_ld[j] && ((j + 1) < LOAD_READY);
        end
      end
      if (!bus.id_src_used[i] || (bus.id_src[5*i +: 5] == ZR)) begin
        match_idx[i] = '0;
        hz[i]        = 1'b0;
      end
      any_hz = any_hz | hz[i];
    end
  end

  // flush wins over a hazard: the killed instruction needs no data.
  assign stall = bus.id_valid && !bus.flush && any_hz;
  assign kill  = stall || bus.flush || !bus.id_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < NSTAGES; j++) begin
        sh_v[j]  <= 1'b0;
        sh_rd[j] <= 5'd0;
        sh_wr[j] <= 1'b0;
        sh_ld[j] <= 1'b0;
      end
      fwd_q <= '0;
      cnt_q <= '0;
    end else begin
      for (int j = NSTAGES - 1; j >= 1; j--) begin
        sh_v[j]  <= sh_v[j-1];
        sh_rd[j] <= sh_rd[j-1];
        sh_wr[j] <= sh_wr[j-1];
        sh_ld[j] <= sh_ld[j-1];
      end
      sh_v[0]  <= !kill;
      sh_rd[0] <= bus.id_rd;
      sh_wr[0] <= bus.id_regwrite;
      sh_ld[0] <= bus.id_is_load;

      for (int i = 0; i < NREAD; i++) begin
        fwd_q[SELW*i +: SELW] <= kill ? '0 : match_idx[i];
      end

      if (bus.cnt_clr) begin
        cnt_q <= '0;
      end else if (stall && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.stall     = stall;
  assign bus.fwd_sel   = fwd_q;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  // a: defaults. b: NSTAGES=3, LOAD_READY=3. c: defaults with a 3-bit counter.
  fwd_hazard_unit_if #(.NREAD(2), .SELW(2), .CNT_W(16)) bus_a ();
  fwd_hazard_unit_if #(.NREAD(2), .SELW(2), .CNT_W(16)) bus_b ();
  fwd_hazard_unit_if #(.NREAD(2), .SELW(2), .CNT_W(3))  bus_c ();

  fwd_hazard_unit dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  fwd_hazard_unit #(.NSTAGES(3), .LOAD_READY(3)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  fwd_hazard_unit #(.CNT_W(3)) dut_c (.clk(clk), .reset(reset), .bus(bus_c));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] used, input logic [4:0] rd, input logic wr,
                       input logic ld, input logic fl, input logic clr);
    bus_a.id_valid = v; bus_a.id_src = {s1, s0}; bus_a.id_src_used = used;
    bus_a.id_rd = rd; bus_a.id_regwrite = wr; bus_a.id_is_load = ld;
    bus_a.flush = fl; bus_a.cnt_clr = clr;
    bus_b.id_valid = v; bus_b.id_src = {s1, s0}; bus_b.id_src_used = used;
    bus_b.id_rd = rd; bus_b.id_regwrite = wr; bus_b.id_is_load = ld;
    bus_b.flush = fl; bus_b.cnt_clr = clr;
    bus_c.id_valid = v; bus_c.id_src = {s1, s0}; bus_c.id_src_used = used;
    bus_c.id_rd = rd; bus_c.id_regwrite = wr; bus_c.id_is_load = ld;
    bus_c.flush = fl; bus_c.cnt_clr = clr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic clr);
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, clr);
    for (int k = 0; k < n; k++) tick();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus_a.stall !== 1'b0 || bus_a.fwd_sel !== 4'd0 || bus_a.stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_state got stall=%0b fwd=%0h cnt=%0h exp 0/0/0",
               bus_a.stall, bus_a.fwd_sel, bus_a.stall_cnt);
    end
    reset = 1'b0;
    idle(3, 1'b0);
  endtask

  task automatic test_alu_forward;
    idle(3, 1'b0);
    drive(1'b1, 5'd10, 5'd11, 2'b11, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);   // ADD x1
    tick();
    drive(1'b1, 5'd1, 5'd12, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);    // SUB reads x1
    #1;
    checks++;
    if (bus_a.stall !== 1'b0) begin
      failures++; $display("FAIL alu_fwd_stall got=%0b exp=0", bus_a.stall);
    end
    tick();
    checks++;
    if (bus_a.fwd_sel !== 4'b0001) begin
      failures++; $display("FAIL alu_fwd_sel got=%0h exp=1", bus_a.fwd_sel);
    end
  endtask

  task automatic test_load_use;
    idle(3, 1'b1);
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);     // LDUR x2
    tick();
    drive(1'b1, 5'd2, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);     // ADD x3,x2,x2
    #1;
    checks++;
    if (bus_a.stall !== 1'b1) begin
      failures++; $display("FAIL load_use_stall got=%0b exp=1", bus_a.stall);
    end
    tick();
    checks++;
    if (bus_a.stall !== 1'b0 || bus_a.stall_cnt !== 16'd1) begin
      failures++;
      $display("FAIL load_use_release got stall=%0b cnt=%0d exp 0/1", bus_a.stall, bus_a.stall_cnt);
    end
    tick();
    checks++;
    if (bus_a.fwd_sel !== 4'b1010) begin
      failures++; $display("FAIL load_use_fwd got=%0h exp=a", bus_a.fwd_sel);
    end
  endtask

  task automatic test_youngest;
    idle(3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus_b.stall !== 1'b0) begin
      failures++; $display("FAIL youngest_stall got=%0b exp=0", bus_b.stall);
    end
    tick();
    checks++;
    if (bus_b.fwd_sel !== 4'b0001) begin
      failures++; $display("FAIL youngest_fwd got=%0h exp=1", bus_b.fwd_sel);
    end
    idle(3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    idle(1, 1'b0);
    drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus_b.fwd_sel !== 4'b0010) begin
      failures++; $display("FAIL bubble_fwd got=%0h exp=2", bus_b.fwd_sel);
    end
  endtask

  task automatic test_no_match;
    idle(3, 1'b0);
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0);   // load to x31
    tick();
    drive(1'b1, 5'd31, 5'd31, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus_a.stall !== 1'b0) begin
      failures++; $display("FAIL zero_reg_stall got=%0b exp=0", bus_a.stall);
    end
    tick();
    checks++;
    if (bus_a.fwd_sel !== 4'b0000) begin
      failures++; $display("FAIL zero_reg_fwd got=%0h exp=0", bus_a.fwd_sel);
    end
    idle(3, 1'b0);
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0);    // no regwrite
    tick();
    drive(1'b1, 5'd4, 5'd4, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus_a.stall !== 1'b0) begin
      failures++; $display("FAIL nowrite_stall got=%0b exp=0", bus_a.stall);
    end
    tick();
    checks++;
    if (bus_a.fwd_sel !== 4'b0000) begin
      failures++; $display("FAIL nowrite_fwd got=%0h exp=0", bus_a.fwd_sel);
    end
  endtask

  task automatic test_flush;
    idle(3, 1'b1);
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);    // load x7
    tick();
    drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);    // use x7, flushed
    #1;
    checks++;
    if (bus_a.stall !== 1'b0) begin
      failures++; $display("FAIL flush_stall got=%0b exp=0", bus_a.stall);
    end
    tick();
    checks++;
    if (bus_a.fwd_sel !== 4'b0000 || bus_a.stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL flush_fwd got fwd=%0h cnt=%0d exp 0/0", bus_a.fwd_sel, bus_a.stall_cnt);
    end
    // The flushed x9 writer must not be visible; the load is now at index 2.
    drive(1'b1, 5'd7, 5'd9, 2'b11, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus_a.stall !== 1'b0) begin
      failures++; $display("FAIL flush_bubble_stall got=%0b exp=0", bus_a.stall);
    end
    tick();
    checks++;
    if (bus_a.fwd_sel !== 4'b0010) begin
      failures++; $display("FAIL flush_bubble_fwd got=%0h exp=2", bus_a.fwd_sel);
    end
  endtask

  task automatic test_late_load;
    idle(3, 1'b1);
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd2, 5'd0, 2'b01, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus_b.stall !== 1'b1) begin
      failures++; $display("FAIL late_stall1 got=%0b exp=1", bus_b.stall);
    end
    tick();
    checks++;
    if (bus_b.stall !== 1'b1 || bus_b.fwd_sel !== 4'b0000) begin
      failures++;
      $display("FAIL late_stall2 got stall=%0b fwd=%0h exp 1/0", bus_b.stall, bus_b.fwd_sel);
    end
    tick();
    checks++;
    if (bus_b.stall !== 1'b0 || bus_b.stall_cnt !== 16'd2) begin
      failures++;
      $display("FAIL late_release got stall=%0b cnt=%0d exp 0/2", bus_b.stall, bus_b.stall_cnt);
    end
    tick();
    checks++;
    if (bus_b.fwd_sel !== 4'b0011) begin
      failures++; $display("FAIL late_fwd got=%0h exp=3", bus_b.fwd_sel);
    end
  endtask

  task automatic test_reset_mid_stall;
    idle(3, 1'b1);
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);    // load x2
    tick();
    drive(1'b1, 5'd2, 5'd0, 2'b01, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);    // load x3 reading x2
    tick();                                                           // one stall
    tick();                                                           // load x3 enters EX
    drive(1'b1, 5'd3, 5'd0, 2'b01, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);    // use x3
    #1;
    checks++;
    if (bus_a.stall !== 1'b1 || bus_a.fwd_sel !== 4'b0010 || bus_a.stall_cnt !== 16'd1) begin
      failures++;
      $display("FAIL pre_reset got stall=%0b fwd=%0h cnt=%0d exp 1/2/1",
               bus_a.stall, bus_a.fwd_sel, bus_a.stall_cnt);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus_a.stall !== 1'b0 || bus_a.fwd_sel !== 4'b0000 || bus_a.stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL mid_stall_reset got stall=%0b fwd=%0h cnt=%0d exp 0/0/0",
               bus_a.stall, bus_a.fwd_sel, bus_a.stall_cnt);
    end
    reset = 1'b0;
    idle(3, 1'b0);
  endtask

  task automatic test_saturate;
    idle(3, 1'b1);
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5'd2, 5'd0, 2'b01, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    checks++;
    if (bus_c.stall_cnt !== 3'd7) begin
      failures++; $display("FAIL sat_reach got=%0d exp=7", bus_c.stall_cnt);
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5'd2, 5'd0, 2'b01, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (bus_c.stall !== 1'b1) begin
        failures++; $display("FAIL sat_stall got=%0b exp=1", bus_c.stall);
      end
      tick();
    end
    checks++;
    if (bus_c.stall_cnt !== 3'd7) begin
      failures++; $display("FAIL sat_hold got=%0d exp=7", bus_c.stall_cnt);
    end
    idle(2, 1'b0);
  endtask

  task automatic test_clr_priority;
    checks++;
    if (bus_a.stall_cnt !== 16'd9) begin
      failures++; $display("FAIL cnt_before_clr got=%0d exp=9", bus_a.stall_cnt);
    end
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd2, 5'd0, 2'b01, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus_a.stall !== 1'b1) begin
      failures++; $display("FAIL clr_stall got=%0b exp=1", bus_a.stall);
    end
    tick();
    checks++;
    if (bus_a.stall_cnt !== 16'd0) begin
      failures++; $display("FAIL clr_priority got=%0d exp=0", bus_a.stall_cnt);
    end
    idle(2, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_alu_forward();
    test_load_use();
    test_youngest();
    test_no_match();
    test_flush();
    test_late_load();
    test_reset_mid_stall();
    test_saturate();
    test_clr_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
